// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter and the CPU top level.
package mem_port_arbiter_pkg;

    localparam int unsigned MAX_MEM_LATENCY = 4;
    localparam int unsigned CNT_W           = $clog2(MAX_MEM_LATENCY);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    localparam logic [1:0] REQ_IF = 2'd0;
    localparam logic [1:0] REQ_D  = 2'd1;
    localparam logic [1:0] REQ_LD = 2'd2;

    // Grant attributes latched alongside the address and write data.
    typedef struct packed {
        logic [1:0] id;
        logic       we;
    } grant_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Read-latency down-counter: loaded in ISSUE, decremented in WAIT, flags zero.
module mem_wait_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             done_c
);

    // Count register; never decrements past zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (ld > d > if) req/ack arbiter in front of a single-port memory.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              busy
);

    localparam logic [1:0] IDLE  = ARB_IDLE;
    localparam logic [1:0] ISSUE = ARB_ISSUE;
    localparam logic [1:0] WAIT  = ARB_WAIT;
    localparam logic [1:0] RESP  = ARB_RESP;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    grant_t            gnt;
    grant_t            sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              any_req;
    logic [DATA_W-1:0] rd_data;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_done;
    logic [CNT_W-1:0]  cnt_value;

    assign any_req = if_req | d_req | ld_req;

    // Priority select of the requester that would win in IDLE.
    always_comb begin
        sel.id    = REQ_IF;
        sel.we    = 1'b0;
        sel_addr  = if_addr;
        sel_wdata = '0;
        if (ld_req) begin
            sel.id    = REQ_LD;
            sel.we    = 1'b1;
            sel_addr  = ld_addr;
            sel_wdata = ld_wdata;
        end else if (d_req) begin
            sel.id    = REQ_D;
            sel.we    = d_we;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end
    end

    // Next-state logic and counter controls.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (gnt.we) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                    cnt_load  = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_done) begin
                    state_nxt = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant capture; the memory address/data ports are the latched values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if ((state == IDLE) && any_req) begin
            gnt       <= sel;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
        end
    end

    // Memory strobes and ack pulses, registered against the upcoming state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            ld_ack <= 1'b0;
        end else begin
            mem_en <= (state_nxt == ISSUE);
            mem_we <= (state_nxt == ISSUE) && sel.we;
            if_ack <= (state_nxt == RESP) && (gnt.id == REQ_IF);
            d_ack  <= (state_nxt == RESP) && (gnt.id == REQ_D);
            ld_ack <= (state_nxt == RESP) && (gnt.id == REQ_LD);
        end
    end

    // Read register: captures memory data on the last WAIT cycle only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if ((state == WAIT) && cnt_done) begin
            rd_data <= mem_rdata;
        end
    end

    mem_wait_counter u_wait_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_W'(MEM_LATENCY - 1)),
        .dec      (cnt_dec),
        .count    (cnt_value),
        .done_c   (cnt_done)
    );

    assign if_rdata = rd_data;
    assign d_rdata  = rd_data;
    assign stall    = (if_req & ~if_ack) | (d_req & ~d_ack);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter at memory latencies 1, 3 and 4.
module tb_mem_port_arbiter;

    logic clk;
    int   total  = 0;
    int   bad    = 0;
    int   n_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background memory contents for locations never written.
    function automatic logic [15:0] init_w(input logic [15:0] a);
        return (a * 16'd7) ^ 16'hA5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

        logic        reset;
        logic        if_req, if_ack, d_req, d_we, d_ack, ld_req, ld_ack;
        logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, ld_addr, ld_wdata;
        logic        mem_en, mem_we, stall, busy;
        logic [15:0] mem_addr, mem_wdata, mem_rdata;

        mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(L)) dut (
            .clock(clk), .reset(reset),
            .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_rdata(d_rdata), .d_ack(d_ack),
            .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata), .stall(stall), .busy(busy)
        );

        // Memory macro: synchronous single port, read data L cycles after mem_en.
        bit   [15:0] mem     [0:65535];
        bit          mem_vld [0:65535];
        logic [15:0] pipe    [0:3];

        always @(posedge clk) begin
            if (mem_en && mem_we) begin
                mem[mem_addr]     <= mem_wdata;
                mem_vld[mem_addr] <= 1'b1;
            end
            pipe[0] <= (mem_en && !mem_we) ?
                       (mem_vld[mem_addr] ? mem[mem_addr] : init_w(mem_addr)) : 16'hDEAD;
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
        end
        assign mem_rdata = pipe[L-1];

        // Reference memory view, updated in arbitration order.
        logic [15:0] ref_mem [logic [15:0]];
        bit   [2:0]  s_on;
        int          s_start [3];
        logic [15:0] s_addr  [3];
        logic [15:0] s_wdata [3];
        bit          s_we;

        function automatic logic [15:0] ref_rd(input logic [15:0] a);
            return ref_mem.exists(a) ? ref_mem[a] : init_w(a);
        endfunction

        task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
            check($sformatf("L%0d_%s", L, tag), got, exp);
        endtask

        task automatic set_scn(input bit [2:0] on, input int st0, input int st1, input int st2,
                               input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                               input logic [15:0] w1, input logic [15:0] w2, input bit we);
            s_on = on;
            s_start[0] = st0; s_start[1] = st1; s_start[2] = st2;
            s_addr[0] = a0;   s_addr[1] = a1;   s_addr[2] = a2;
            s_wdata[0] = '0;  s_wdata[1] = w1;  s_wdata[2] = w2;
            s_we = we;
        endtask

        function automatic logic [15:0] pick_addr();
            case ($urandom_range(0, 3))
                0:       return 16'h0042;
                1:       return 16'h0100;
                2:       return 16'h0010;
                default: return 16'($urandom);
            endcase
        endfunction

        // Schedules the scenario from the priority/latency rules, then drives and checks each cycle.
        task automatic run_scn();
            int          arb [3];
            int          ack [3];
            logic [15:0] exp_rd [3];
            bit          wr  [3];
            bit          drv [3];
            int          t, left, w, ei;
            bit   [2:0]  eack;
            bit          een, ebusy, estall;
            left = 0;
            for (int i = 0; i < 3; i++) begin
                arb[i] = -1; ack[i] = -1; exp_rd[i] = '0;
                wr[i]  = (i == 2) || ((i == 1) && s_we);
                if (s_on[i]) left++;
            end
            t = 0;
            while (left > 0) begin
                w = -1;
                for (int i = 2; i >= 0; i--)
                    if (w < 0 && s_on[i] && ack[i] < 0 && s_start[i] <= t) w = i;
                if (w < 0) begin
                    t++;
                end else begin
                    arb[w] = t;
                    ack[w] = t + (wr[w] ? 2 : 2 + int'(L));
                    if (wr[w]) ref_mem[s_addr[w]] = s_wdata[w];
                    else       exp_rd[w] = ref_rd(s_addr[w]);
                    t = ack[w] + 1;
                    left--;
                end
            end
            for (int k = 0; k <= t; k++) begin
                @(posedge clk); #1;
                for (int i = 0; i < 3; i++)
                    drv[i] = s_on[i] && (k >= s_start[i]) && (k <= ack[i]);
                if_req   = drv[0];
                if_addr  = (drv[0] && k > arb[0]) ? 16'($urandom) : s_addr[0];
                d_req    = drv[1];
                d_we     = drv[1] ? s_we : 1'($urandom);
                d_addr   = (drv[1] && k > arb[1]) ? 16'($urandom) : s_addr[1];
                d_wdata  = (drv[1] && k > arb[1]) ? 16'($urandom) : s_wdata[1];
                ld_req   = drv[2];
                ld_addr  = (drv[2] && k > arb[2]) ? 16'($urandom) : s_addr[2];
                ld_wdata = (drv[2] && k > arb[2]) ? 16'($urandom) : s_wdata[2];
                @(negedge clk);
                eack = '0; een = 1'b0; ei = 0; ebusy = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    if (ack[i] == k) eack[i] = 1'b1;
                    if (arb[i] >= 0 && arb[i] + 1 == k) begin een = 1'b1; ei = i; end
                    if (arb[i] >= 0 && k > arb[i] && k <= ack[i]) ebusy = 1'b1;
                end
                estall = (drv[0] & ~eack[0]) | (drv[1] & ~eack[1]);
                chk("ack", 32'({ld_ack, d_ack, if_ack}), 32'(eack));
                chk("en_we", 32'({mem_en, mem_we}), 32'({een, een & wr[ei]}));
                chk("busy", 32'(busy), 32'(ebusy));
                chk("stall", 32'(stall), 32'(estall));
                if (een) begin
                    chk("mem_addr", 32'(mem_addr), 32'(s_addr[ei]));
                    if (wr[ei]) chk("mem_wdata", 32'(mem_wdata), 32'(s_wdata[ei]));
                end
                if (eack[0]) chk("if_rdata", 32'(if_rdata), 32'(exp_rd[0]));
                if (eack[1] && !wr[1]) chk("d_rdata", 32'(d_rdata), 32'(exp_rd[1]));
            end
            if_req = 1'b0; d_req = 1'b0; ld_req = 1'b0;
        endtask

        initial begin
            reset = 1'b1;
            if_req = 1'b0; d_req = 1'b0; ld_req = 1'b0; d_we = 1'b0;
            if_addr = '0; d_addr = '0; d_wdata = '0; ld_addr = '0; ld_wdata = '0;
            repeat (2) @(posedge clk);
            #1;
            chk("rst_ctl", 32'({mem_en, mem_we, if_ack, d_ack, ld_ack, busy}), 32'd0);
            chk("rst_addr", 32'(mem_addr), 32'd0);
            chk("rst_wdata", 32'(mem_wdata), 32'd0);
            chk("rst_rdata", 32'(if_rdata), 32'd0);
            reset = 1'b0;

            // Loader plants 0xA5C3 at 0x0010, then a single fetch of it.
            set_scn(3'b100, 0, 0, 0, 16'h0, 16'h0, 16'h0010, 16'h0, 16'hA5C3, 1'b0); run_scn();
            set_scn(3'b001, 0, 0, 0, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);   run_scn();
            // Store then load back.
            set_scn(3'b010, 0, 0, 0, 16'h0, 16'h0042, 16'h0, 16'h1234, 16'h0, 1'b1); run_scn();
            set_scn(3'b010, 0, 0, 0, 16'h0, 16'h0042, 16'h0, 16'h0, 16'h0, 1'b0);    run_scn();
            // Fetch and load raised together.
            set_scn(3'b011, 0, 0, 0, 16'h0010, 16'h0005, 16'h0, 16'h0, 16'h0, 1'b0); run_scn();
            // Loader arriving during a fetch.
            set_scn(3'b101, 0, 0, 2, 16'h0100, 16'h0, 16'h0300, 16'h0, 16'hBEEF, 1'b0); run_scn();
            // Fetch and loader both pending; fetch must wait out the loader.
            set_scn(3'b101, 0, 0, 0, 16'h0300, 16'h0, 16'h0200, 16'h0, 16'h7777, 1'b0); run_scn();

            for (int r = 0; r < 24; r++) begin
                set_scn(3'($urandom_range(1, 7)), $urandom_range(0, 4), $urandom_range(0, 4),
                        $urandom_range(0, 4), pick_addr(), pick_addr(), pick_addr(),
                        16'($urandom), 16'($urandom), 1'($urandom));
                run_scn();
            end

            // Reset asserted during WAIT of a fetch.
            @(posedge clk); #1;
            if_req = 1'b1; if_addr = 16'h0200;
            @(posedge clk); #1;
            @(posedge clk); #1;
            reset = 1'b1;
            #1;
            chk("rst_wait_ctl", 32'({mem_en, mem_we, if_ack, d_ack, ld_ack, busy}), 32'd0);
            @(posedge clk); #1;
            if_req = 1'b0;
            chk("rst_wait_hold", 32'({mem_en, if_ack, busy}), 32'd0);
            chk("rst_wait_addr", 32'(mem_addr), 32'd0);
            @(posedge clk); #1;
            reset = 1'b0;
            set_scn(3'b001, 0, 0, 0, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0); run_scn();
            set_scn(3'b010, 1, 0, 0, 16'h0, 16'h0042, 16'h0, 16'h0, 16'h0, 1'b0); run_scn();

            n_done++;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (n_done < 3 && cyc < 50000) begin
            @(posedge clk);
            cyc++;
        end
        check("all_done", 32'(n_done), 32'd3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
